// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: NCORES byte-wide cores, one outstanding access at a time,
// core ID folded into the address. Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_arbiter #(
  parameter int NCORES = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ID_LSB = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        core_memread,
  input  logic [NCORES-1:0]        core_memwrite,
  input  logic [NCORES*ADDR_W-1:0] core_addr,
  input  logic [NCORES*DATA_W-1:0] core_writedata,
  output logic [NCORES*DATA_W-1:0] core_rdata,
  output logic [NCORES-1:0]        core_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);
  localparam int IDW = (NCORES > 2) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                          state_q;
  logic [IDW-1:0]                  grant_q;
  logic                            mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]               mem_addr_q;
  logic [DATA_W-1:0]               mem_wdata_q;
  logic [NCORES-1:0]               core_ready_q;
  logic [NCORES-1:0][DATA_W-1:0]   rdata_q;

  logic [NCORES-1:0][ADDR_W-1:0]   addr_v;
  logic [NCORES-1:0][DATA_W-1:0]   wdata_v;
  logic [NCORES-1:0]               req;
  logic [2*NCORES-1:0]             req2;
  logic [IDW-1:0]                  ptr, off, win;
  logic [IDW:0]                    sum;
  logic [ADDR_W-1:0]               addr_d;

  assign addr_v  = core_addr;
  assign wdata_v = core_writedata;
  assign req     = core_memread | core_memwrite;

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   gnt_inc;

  assign gnt_inc = {1'b0, grant_q} + (IDW+1)'(1);
  assign ptr_d   = (gnt_inc == (IDW+1)'(NCORES)) ? '0 : gnt_inc[IDW-1:0];
  assign ptr     = ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               ptr_q <= '0;
    else if (state_q == ACCESS && mem_ack)    ptr_q <= ptr_d;
  end
`endif

  // Rotate requests so bit 0 is the pointer's core; first set bit is the offset of the winner.
  assign req2 = {req, req} >> ptr;

  always_comb begin
    off = '0;
    for (int k = NCORES-1; k >= 0; k--)
      if (req2[k]) off = IDW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (IDW+1)'(NCORES)) ? IDW'(sum - (IDW+1)'(NCORES)) : sum[IDW-1:0];
  end

  always_comb begin
    addr_d = addr_v[win];
    addr_d[ID_LSB +: IDW] = win;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ready_q <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          core_ready_q <= '0;
          if (|req) begin
            grant_q     <= win;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_v[win];
            mem_write_q <= core_memwrite[win];
            mem_read_q  <= ~core_memwrite[win];
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (mem_read_q) rdata_q[grant_q] <= mem_rdata;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            core_ready_q <= NCORES'(1) << grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          core_ready_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_ready = core_ready_q;
  assign core_rdata = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle on a 2-core
// instance, plus directed literal checks and a 3-core remap check.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 2-core instance
  logic [1:0]  rd0 = '0, wr0 = '0;
  logic [31:0] addr0 = '0;
  logic [15:0] wd0 = '0;
  logic [15:0] rdat0;
  logic [1:0]  rdy0;
  logic        mr0, mw0;
  logic [15:0] ma0;
  logic [7:0]  mwd0;
  logic [7:0]  mrd0 = '0;
  logic        ack0 = 1'b0;

  // 3-core instance
  logic [2:0]  rd1 = '0, wr1 = '0;
  logic [47:0] addr1 = '0;
  logic [23:0] wd1 = '0;
  logic [23:0] rdat1;
  logic [2:0]  rdy1;
  logic        mr1, mw1;
  logic [15:0] ma1;
  logic [7:0]  mwd1;
  logic [7:0]  mrd1 = 8'h11;
  logic        ack1 = 1'b0;

  mem_arbiter #(.NCORES(2), .ADDR_W(16), .DATA_W(8), .ID_LSB(8)) u0 (
    .clk(clk), .reset(reset), .core_memread(rd0), .core_memwrite(wr0),
    .core_addr(addr0), .core_writedata(wd0), .core_rdata(rdat0), .core_ready(rdy0),
    .mem_read(mr0), .mem_write(mw0), .mem_addr(ma0), .mem_wdata(mwd0),
    .mem_rdata(mrd0), .mem_ack(ack0));

  mem_arbiter #(.NCORES(3), .ADDR_W(16), .DATA_W(8), .ID_LSB(8)) u1 (
    .clk(clk), .reset(reset), .core_memread(rd1), .core_memwrite(wr1),
    .core_addr(addr1), .core_writedata(wd1), .core_rdata(rdat1), .core_ready(rdy1),
    .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1), .mem_wdata(mwd1),
    .mem_rdata(mrd1), .mem_ack(ack1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack after wait_n stall cycles; stray acks only while idle.
  int wait_n = 0;
  int wcnt   = 0;
  bit stray  = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mr0 | mw0) begin
      ack0 = (wcnt == wait_n);
      wcnt++;
    end else begin
      ack0 = stray;
      wcnt = 0;
    end
    ack1 = mr1 | mw1;
  end

  // Transaction-level model of the 2-core instance.
  bit        m_busy, m_resp, m_wr;
  int        m_core, m_ptr;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic [7:0]  m_rd [2];

  function automatic logic [15:0] remap(input logic [15:0] a, input int c);
    logic [15:0] mask;
    mask = 16'h0100;
    return (a & ~mask) | (16'(c) << 8);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 0; m_resp = 0; m_wr = 0; m_core = 0; m_ptr = 0;
      m_addr = '0; m_data = '0; m_rd[0] = '0; m_rd[1] = '0;
    end
    chk("mem_read",   mr0,  m_busy && !m_wr);
    chk("mem_write",  mw0,  m_busy && m_wr);
    chk("core_ready", rdy0, m_resp ? (2'b01 << m_core) : 2'b00);
    chk("core_rdata", rdat0, {m_rd[1], m_rd[0]});
    if (m_busy) begin
      chk("mem_addr",  ma0,  m_addr);
      chk("mem_wdata", mwd0, m_data);
    end
    if (reset) begin
      if (m_resp) m_resp = 0;
      else if (m_busy) begin
        if (ack0) begin
          if (!m_wr) m_rd[m_core] = mrd0;
`ifdef ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (m_core + 1) % 2;
`endif
          m_busy = 0;
          m_resp = 1;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          int c;
          c = (m_ptr + k) % 2;
          if (!m_busy && (rd0[c] | wr0[c])) begin
            m_busy = 1;
            m_core = c;
            m_wr   = wr0[c];
            m_addr = remap(addr0[c*16 +: 16], c);
            m_data = wd0[c*8 +: 8];
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string nm);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (mr0 | mw0) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: no strobe within 20 cycles, expected one", nm);
  endtask

  initial begin
    int exp_g [4];
    logic [15:0] exp_rd_after;
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
    exp_rd_after = 16'hA577;
`else
    exp_g = '{0, 1, 0, 1};
    exp_rd_after = 16'h7777;
`endif
    cyc(3);
    chk("reset rdata", rdat0, 16'h0000);
    chk("reset ready", rdy0, 2'b00);
    chk("reset strobes", {mr0, mw0}, 2'b00);
    reset = 1'b1;
    cyc(2);

    // single read, zero-wait
    mrd0 = 8'hA5; rd0 = 2'b10; addr0[31:16] = 16'h1234;
    cyc(1);
    chk("t1 mem_read", mr0, 1'b1);
    chk("t1 mem_addr", ma0, 16'h1334);
    cyc(1);
    chk("t1 ready", rdy0, 2'b10);
    rd0 = 2'b00;
    cyc(1);
    chk("t1 rdata", rdat0, 16'hA500);

    // contention
    mrd0 = 8'h77; addr0 = {16'h0020, 16'h0010}; rd0 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_strobe("t2 strobe");
      chk("t2 grant", 32'(ma0[8]), 32'(exp_g[k]));
    end
    rd0 = 2'b00;
    cyc(3);

    // write with remap
    wr0 = 2'b01; addr0[15:0] = 16'h01FF; wd0[7:0] = 8'h3C;
    wait_strobe("t3 strobe");
    chk("t3 mem_write", {mw0, mr0}, 2'b10);
    chk("t3 mem_addr", ma0, 16'h00FF);
    chk("t3 mem_wdata", mwd0, 8'h3C);
    cyc(1);
    chk("t3 ready", rdy0, 2'b01);
    wr0 = 2'b00;
    cyc(1);
    chk("t3 rdata kept", rdat0, exp_rd_after);

    // stray ack while idle
    stray = 1'b1;
    cyc(3);
    stray = 1'b0;
    chk("stray ack ready", rdy0, 2'b00);

    // wait states, address changes mid-access
    wait_n = 3; mrd0 = 8'h5E; rd0 = 2'b01; addr0[15:0] = 16'h0042;
    wait_strobe("t4 strobe");
    addr0[15:0] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("t4 strobe held", mr0, 1'b1);
      chk("t4 addr held", ma0, 16'h0042);
      chk("t4 no early ready", rdy0, 2'b00);
      cyc(1);
    end
    chk("t4 ready", rdy0, 2'b01);
    rd0 = 2'b00; wait_n = 0;
    cyc(1);
    chk("t4 rdata", rdat0[7:0], 8'h5E);

    // reset mid-access, then pointer must be back at core 0
    wait_n = 5; rd0 = 2'b10; addr0[31:16] = 16'h0100;
    wait_strobe("t5 strobe");
    cyc(1);
    reset = 1'b0;
    #1;
    chk("t5 strobes", {mr0, mw0}, 2'b00);
    chk("t5 ready", rdy0, 2'b00);
    chk("t5 rdata", rdat0, 16'h0000);
    cyc(1);
    wait_n = 0; rd0 = 2'b11; reset = 1'b1;
    wait_strobe("t5 regrant");
    chk("t5 first grant", ma0[8], 1'b0);
    rd0 = 2'b00;
    cyc(4);

    // 3-core: read+write both high on core 2 -> write, ID 2'b10
    rd1[2] = 1'b1; wr1[2] = 1'b1; addr1[47:32] = 16'hABCD; wd1[23:16] = 8'h99;
    cyc(1);
    chk("t6 strobes", {mw1, mr1}, 2'b10);
    chk("t6 mem_addr", ma1, 16'hAACD);
    chk("t6 mem_wdata", mwd1, 8'h99);
    cyc(1);
    chk("t6 ready", rdy1, 3'b100);
    rd1 = '0; wr1 = '0;
    cyc(2);
    chk("t6 rdata", rdat1, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end
endmodule
